ifft_frame_player: RTL and testbench
====================================

# ifft_frame_player

Ping-pong frame buffer and rate-converting playback engine for the vocoder output path. Captures complete frames of real IFFT output samples at the IFFT burst rate and replays each stored sample for a parametrised number of clock cycles (sample-and-hold upsampling) toward the DAC/audio path. Sits directly after the IFFT and generalises the single-RAM, fixed divide-by-16 playback used in verification into a parametrised, double-buffered block with overflow and underrun status.

## Interface
- DATA_W, 24, sample width (IFFT real output).
- FRAME_LEN, 1024, samples per frame; power of two, ≥4.
- HOLD, 16, clock cycles each sample is presented; ≥1.
- AW, $clog2(FRAME_LEN), address width (derived, not overridden).
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_data is a valid sample this cycle.
- in_data  in  DATA_W  signed IFFT output sample.
- out_data  out  DATA_W  signed playback sample, held between updates.
- out_valid  out  1  one-cycle strobe when out_data takes a new sample.
- out_frame_start  out  1  coincident with out_valid for sample 0 of a frame.
- playing  out  1  read FSM in PLAY.
- overflow  out  1  sticky: input sample dropped because target bank full.
- underrun  out  1  sticky: playback ran out of frames after starting.

## Operation
- Storage: two banks of FRAME_LEN × DATA_W, simple dual-port, synchronous read (1-cycle latency). Flags full[1:0].
- Write side: wbank, waddr. On in_valid with full[wbank]=0: write in_data at {wbank,waddr}, waddr++. On write at waddr=FRAME_LEN-1: set full[wbank], toggle wbank, waddr wraps to 0.
- On in_valid with full[wbank]=1: sample discarded, waddr unchanged, overflow set. Frame continues filling once bank frees; no resynchronisation.
- Read FSM states IDLE, PLAY; registers rbank, raddr, hold_cnt (0..HOLD-1).
- IDLE → PLAY when full[rbank]=1; raddr=0, hold_cnt=0.
- PLAY, hold_cnt=0: issue read {rbank,raddr}. hold_cnt increments, wraps at HOLD-1.
- PLAY, hold_cnt=HOLD-1: if raddr<FRAME_LEN-1, raddr++; else clear full[rbank], toggle rbank, raddr=0, then PLAY if other bank full (gapless), else IDLE and set underrun.
- HOLD=1: read every cycle, one sample per cycle.
- out_data registered from RAM output one cycle after read issue; holds last value in IDLE.
- full flags: set by write side, cleared by read side; different banks per cycle never conflict. Write side uses registered full; a sample arriving on the cycle its bank is cleared is dropped (overflow).
- Width: no arithmetic on data; pure storage, bit-exact.

## Timing
- Reset values: out_data 0, out_valid 0, out_frame_start 0, playing 0, overflow 0, underrun 0, full 2'b00, wbank 0, rbank 0, waddr 0, raddr 0, FSM IDLE.
- Reset mid-frame: all pending data discarded; next in_valid writes bank 0 addr 0.
- Last write of frame on edge T: full set at T; FSM enters PLAY at T+1 and issues read of addr 0 in that cycle; out_valid/out_frame_start at T+2 with sample 0.
- Sample k appears at T+2+k·HOLD; frame duration FRAME_LEN·HOLD cycles.
- Bank freed (full cleared) on edge after sample FRAME_LEN-1's final hold cycle.
- Gapless back-to-back: sample 0 of next frame exactly HOLD cycles after last sample of previous.
- playing high from T+1 until the edge leaving PLAY.

## Test plan
- FRAME_LEN=8, HOLD=4; reset, write 8 samples 1..8 back-to-back -> out_valid every 4 cycles, values 1..8, first 2 cycles after last write, out_frame_start only with value 1; then underrun=1, playing=0.
- Same params, two frames (1..8, 9..16) written consecutively -> 16 outputs spaced exactly 4 cycles, no gap, underrun set only after value 16.
- Three frames written back-to-back with no pause -> frames 1,2 played; frame 3 samples dropped while both banks full, overflow=1; dropped count matches cycles before bank 0 frees.
- HOLD=1, FRAME_LEN=8 -> outputs on 8 consecutive cycles, out_valid continuous.
- Assert reset after 5 of 8 samples written and during playback -> all outputs/flags return to reset values; subsequent full frame plays correctly from bank 0.
- Default params (1024, 16), random sparse in_valid -> output sequence bit-exact to input, 16 cycles per sample, no overflow.

Source files
------------

// File: rtl/ifft_frame_player.sv
// Ping-pong frame buffer with sample-and-hold playback: out_valid 2 cycles after a frame's last write, then one sample per HOLD cycles.
// No backpressure: input samples arriving while the target bank is still full are dropped and flagged in overflow.
module ifft_frame_player #(
    parameter int DATA_W    = 24,
    parameter int FRAME_LEN = 1024,
    parameter int HOLD      = 16,
    localparam int AW       = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_frame_start,
    output logic              playing,
    output logic              overflow,
    output logic              underrun
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);
    localparam logic [HW-1:0] LAST_HOLD = HW'(HOLD - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    logic [DATA_W-1:0] mem [2*FRAME_LEN];

    state_t            state_q, state_d;
    logic              wbank_q, wbank_d;
    logic [AW-1:0]     waddr_q, waddr_d;
    logic [1:0]        full_q, full_d, full_set, full_clr;
    logic              rbank_q, rbank_d;
    logic [AW-1:0]     raddr_q, raddr_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q, out_valid_d;
    logic              fs_q, fs_d;
    logic              overflow_q, overflow_d;
    logic              underrun_q, underrun_d;
    logic              wr_en, rd_en;

    always_comb begin
        wbank_d     = wbank_q;
        waddr_d     = waddr_q;
        full_set    = 2'b00;
        full_clr    = 2'b00;
        overflow_d  = overflow_q;
        wr_en       = 1'b0;
        if (in_valid) begin
            if (full_q[wbank_q]) begin
                overflow_d = 1'b1;
            end else begin
                wr_en   = 1'b1;
                waddr_d = waddr_q + 1'b1;
                if (waddr_q == LAST_ADDR) begin
                    full_set[wbank_q] = 1'b1;
                    wbank_d           = ~wbank_q;
                end
            end
        end

        state_d     = state_q;
        rbank_d     = rbank_q;
        raddr_d     = raddr_q;
        hold_d      = hold_q;
        underrun_d  = underrun_q;
        rd_en       = 1'b0;
        out_valid_d = 1'b0;
        fs_d        = 1'b0;
        case (state_q)
            IDLE: begin
                raddr_d = '0;
                hold_d  = '0;
                if (full_q[rbank_q]) state_d = PLAY;
            end
            PLAY: begin
                if (hold_q == '0) begin
                    rd_en       = 1'b1;
                    out_valid_d = 1'b1;
                    fs_d        = (raddr_q == '0);
                end
                if (hold_q == LAST_HOLD) begin
                    hold_d = '0;
                    if (raddr_q != LAST_ADDR) begin
                        raddr_d = raddr_q + 1'b1;
                    end else begin
                        // Registered full of the other bank decides gapless vs. underrun.
                        full_clr[rbank_q] = 1'b1;
                        rbank_d           = ~rbank_q;
                        raddr_d           = '0;
                        if (!full_q[~rbank_q]) begin
                            state_d    = IDLE;
                            underrun_d = 1'b1;
                        end
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        full_d = (full_q | full_set) & ~full_clr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wbank_q     <= 1'b0;
            waddr_q     <= '0;
            full_q      <= 2'b00;
            rbank_q     <= 1'b0;
            raddr_q     <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            fs_q        <= 1'b0;
            overflow_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wbank_q     <= wbank_d;
            waddr_q     <= waddr_d;
            full_q      <= full_d;
            rbank_q     <= rbank_d;
            raddr_q     <= raddr_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            fs_q        <= fs_d;
            overflow_q  <= overflow_d;
            underrun_q  <= underrun_d;
            if (rd_en) out_data_q <= mem[{rbank_q, raddr_q}];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[{wbank_q, waddr_q}] <= in_data;
    end

    assign out_data        = out_data_q;
    assign out_valid       = out_valid_q;
    assign out_frame_start = fs_q;
    assign playing         = (state_q == PLAY);
    assign overflow        = overflow_q;
    assign underrun        = underrun_q;

endmodule

// File: tb/tb_ifft_frame_player.sv
// Scoreboard bench: three player instances (8x4, 8x1, 1024x16); stimulus pushes expected
// {sample, frame_start, cycle}, per-instance monitors pop and compare on out_valid.
module tb_ifft_frame_player;
    localparam int DW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic          fs;
        int            t;
    } exp_t;

    exp_t qa[$], qb[$], qc[$];

    logic          a_rst = 1'b1, a_vld = 1'b0, a_ov, a_fs, a_pl, a_of, a_ur;
    logic [DW-1:0] a_dat = '0, a_od;
    logic          b_rst = 1'b1, b_vld = 1'b0, b_ov, b_fs, b_pl, b_of, b_ur;
    logic [DW-1:0] b_dat = '0, b_od;
    logic          c_rst = 1'b1, c_vld = 1'b0, c_ov, c_fs, c_pl, c_of, c_ur;
    logic [DW-1:0] c_dat = '0, c_od;

    ifft_frame_player #(.DATA_W(DW), .FRAME_LEN(8), .HOLD(4)) dut_a (
        .clk(clk), .reset(a_rst), .in_valid(a_vld), .in_data(a_dat),
        .out_data(a_od), .out_valid(a_ov), .out_frame_start(a_fs),
        .playing(a_pl), .overflow(a_of), .underrun(a_ur));

    ifft_frame_player #(.DATA_W(DW), .FRAME_LEN(8), .HOLD(1)) dut_b (
        .clk(clk), .reset(b_rst), .in_valid(b_vld), .in_data(b_dat),
        .out_data(b_od), .out_valid(b_ov), .out_frame_start(b_fs),
        .playing(b_pl), .overflow(b_of), .underrun(b_ur));

    ifft_frame_player #(.DATA_W(DW), .FRAME_LEN(1024), .HOLD(16)) dut_c (
        .clk(clk), .reset(c_rst), .in_valid(c_vld), .in_data(c_dat),
        .out_data(c_od), .out_valid(c_ov), .out_frame_start(c_fs),
        .playing(c_pl), .overflow(c_of), .underrun(c_ur));

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", n, act, exp, cyc);
        end
    endtask

    // Monitors: compare every output strobe against the head of its queue.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!a_rst && a_fs && !a_ov) chk("a_fs_without_valid", 32'(a_fs), 0);
        if (!a_rst && a_ov) begin
            if (qa.size() == 0) chk("a_unexpected_out", 32'(a_od), 32'hFFFFFFFF);
            else begin
                e = qa.pop_front();
                chk("a_data", 32'(a_od), 32'(e.d));
                chk("a_fs", 32'(a_fs), 32'(e.fs));
                chk("a_time", cyc, e.t);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!b_rst && b_ov) begin
            if (qb.size() == 0) chk("b_unexpected_out", 32'(b_od), 32'hFFFFFFFF);
            else begin
                e = qb.pop_front();
                chk("b_data", 32'(b_od), 32'(e.d));
                chk("b_fs", 32'(b_fs), 32'(e.fs));
                chk("b_time", cyc, e.t);
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (!c_rst && c_ov) begin
            if (qc.size() == 0) chk("c_unexpected_out", 32'(c_od), 32'hFFFFFFFF);
            else begin
                e = qc.pop_front();
                chk("c_data", 32'(c_od), 32'(e.d));
                chk("c_fs", 32'(c_fs), 32'(e.fs));
                chk("c_time", cyc, e.t);
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Drive one sample; t returns the clock edge on which it is written.
    task automatic wr_a(input int v, output int t);
        @(negedge clk);
        a_vld = 1'b1;
        a_dat = DW'(v);
        t = cyc + 1;
    endtask

    task automatic idle_a;
        @(negedge clk);
        a_vld = 1'b0;
    endtask

    task automatic push_a(input int first, input int n, input int t0);
        for (int k = 0; k < n; k++)
            qa.push_back('{d: DW'(first + k), fs: ((k % 8) == 0), t: t0 + k * 4});
    endtask

    task automatic reset_a;
        @(negedge clk);
        a_rst = 1'b1;
        a_vld = 1'b0;
        qa.delete();
        repeat (2) @(negedge clk);
        a_rst = 1'b0;
    endtask

    task automatic chk_rst_a(input string n);
        chk({n, "_out_data"}, 32'(a_od), 0);
        chk({n, "_out_valid"}, 32'(a_ov), 0);
        chk({n, "_frame_start"}, 32'(a_fs), 0);
        chk({n, "_playing"}, 32'(a_pl), 0);
        chk({n, "_overflow"}, 32'(a_of), 0);
        chk({n, "_underrun"}, 32'(a_ur), 0);
    endtask

    initial begin : timeout
        #600000;
        $display("FAIL timeout: simulation did not finish (cyc %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t, tf, last;
        logic [DW-1:0] vals [1024];

        // Single frame 1..8.
        reset_a();
        chk_rst_a("rst0");
        for (int i = 1; i <= 8; i++) begin
            wr_a(i, t);
            if (i == 8) push_a(1, 8, t + 2);
        end
        idle_a();
        chk("t1_playing_before", 32'(a_pl), 0);
        wait_cyc(t + 1);
        chk("t1_playing_start", 32'(a_pl), 1);
        last = t + 2 + 7 * 4;
        wait_cyc(last + 2);
        chk("t1_underrun_early", 32'(a_ur), 0);
        chk("t1_playing_mid", 32'(a_pl), 1);
        wait_cyc(last + 4);
        chk("t1_underrun", 32'(a_ur), 1);
        chk("t1_playing_end", 32'(a_pl), 0);
        chk("t1_overflow", 32'(a_of), 0);
        chk("t1_drain", 32'(qa.size()), 0);

        // Two frames back-to-back, gapless playback.
        reset_a();
        chk_rst_a("rst1");
        for (int i = 1; i <= 16; i++) begin
            wr_a(i, t);
            if (i == 8) begin
                tf = t;
                push_a(1, 16, t + 2);
            end
        end
        idle_a();
        last = tf + 2 + 15 * 4;
        wait_cyc(last + 2);
        chk("t2_underrun_early", 32'(a_ur), 0);
        wait_cyc(last + 4);
        chk("t2_underrun", 32'(a_ur), 1);
        chk("t2_playing_end", 32'(a_pl), 0);
        chk("t2_drain", 32'(qa.size()), 0);

        // Three frames back-to-back: frame 3 dropped entirely, then a later frame fills bank 0.
        reset_a();
        for (int i = 1; i <= 24; i++) begin
            wr_a(i, t);
            if (i == 8) begin
                tf = t;
                push_a(1, 16, t + 2);
                push_a(25, 8, t + 2 + 16 * 4);
            end
            if (i == 17) chk("t3_overflow_before", 32'(a_of), 0);
            if (i == 18) chk("t3_overflow_set", 32'(a_of), 1);
        end
        idle_a();
        // Bank 0 frees on edge tf+33; the first write after that is edge tf+34.
        wait_cyc(tf + 32);
        for (int i = 25; i <= 32; i++) wr_a(i, t);
        idle_a();
        last = tf + 2 + 23 * 4;
        wait_cyc(last + 4);
        chk("t3_overflow_sticky", 32'(a_of), 1);
        chk("t3_underrun", 32'(a_ur), 1);
        chk("t3_drain", 32'(qa.size()), 0);

        // Reset mid-frame and during playback.
        reset_a();
        for (int i = 0; i < 5; i++) wr_a(201 + i, t);
        idle_a();
        reset_a();
        chk_rst_a("rst_midframe");
        for (int i = 0; i < 8; i++) begin
            wr_a(50 + i, t);
            if (i == 7) push_a(50, 8, t + 2);
        end
        idle_a();
        wait_cyc(t + 7);
        reset_a();
        chk_rst_a("rst_playback");
        for (int i = 0; i < 8; i++) begin
            wr_a(60 + i, t);
            if (i == 7) push_a(60, 8, t + 2);
        end
        idle_a();
        last = t + 2 + 7 * 4;
        wait_cyc(last + 4);
        chk("t4_underrun", 32'(a_ur), 1);
        chk("t4_drain", 32'(qa.size()), 0);

        // HOLD=1: eight consecutive output cycles.
        @(negedge clk);
        b_rst = 1'b0;
        chk("b_rst_playing", 32'(b_pl), 0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            b_vld = 1'b1;
            b_dat = DW'(i);
            t = cyc + 1;
        end
        for (int k = 0; k < 8; k++)
            qb.push_back('{d: DW'(k + 1), fs: (k == 0), t: t + 2 + k});
        @(negedge clk);
        b_vld = 1'b0;
        wait_cyc(t + 9 + 3);
        chk("b_underrun", 32'(b_ur), 1);
        chk("b_playing_end", 32'(b_pl), 0);
        chk("b_drain", 32'(qb.size()), 0);

        // Default geometry, random sparse input, random data.
        @(negedge clk);
        c_rst = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                c_vld = 1'b0;
                c_dat = DW'($urandom);
            end
            vals[i] = DW'($urandom);
            @(negedge clk);
            c_vld = 1'b1;
            c_dat = vals[i];
            t = cyc + 1;
        end
        for (int k = 0; k < 1024; k++)
            qc.push_back('{d: vals[k], fs: (k == 0), t: t + 2 + k * 16});
        @(negedge clk);
        c_vld = 1'b0;
        last = t + 2 + 1023 * 16;
        wait_cyc(last + 17);
        chk("c_overflow", 32'(c_of), 0);
        chk("c_underrun", 32'(c_ur), 1);
        chk("c_drain", 32'(qc.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
